// File: rtl/fc_pkg.sv
// Shared definitions for the FC accumulate unit: default widths and FSM state encoding.
package fc_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ACC_WIDTH   = 32;
    localparam int LEN_WIDTH   = 16;
    localparam int SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ROUND  = 2'd2,
        OUTPUT = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fc_accumulate_unit_if.sv
// Valid/ready stream bundle used for both the product input and the result output.
interface fc_accumulate_unit_if #(
    parameter int WIDTH = 2 * fc_pkg::DATA_WIDTH
);

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fc_requant.sv
// Combinational requantizer: rounding right shift of the accumulator, saturated to DATA_WIDTH.
module fc_requant #(
    parameter int DATA_WIDTH  = fc_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH   = fc_pkg::ACC_WIDTH,
    parameter int SHIFT_WIDTH = fc_pkg::SHIFT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [DATA_WIDTH-1:0]  q
);

    // One extra bit keeps the rounding add from wrapping when acc is near full scale.
    function automatic logic [ACC_WIDTH:0] round_shift(input logic [ACC_WIDTH-1:0]   a,
                                                      input logic [SHIFT_WIDTH-1:0] s);
        logic [ACC_WIDTH:0] ext;
        logic [ACC_WIDTH:0] half;
        ext = {1'b0, a};
        if (s == '0) begin
            return ext;
        end
        half = (ACC_WIDTH + 1)'(1) << (s - SHIFT_WIDTH'(1));
        return (ext + half) >> s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [ACC_WIDTH:0] r);
        if (|r[ACC_WIDTH:DATA_WIDTH]) begin
            return {DATA_WIDTH{1'b1}};
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    assign q = saturate(round_shift(acc, shift));

endmodule

// File: rtl/fc_accumulate_unit.sv
// Accumulates one neuron's products from a bias, requantizes, and hands the result downstream.
module fc_accumulate_unit #(
    parameter int DATA_WIDTH  = fc_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH   = fc_pkg::ACC_WIDTH,
    parameter int LEN_WIDTH   = fc_pkg::LEN_WIDTH,
    parameter int SHIFT_WIDTH = fc_pkg::SHIFT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   vec_len,
    input  logic [ACC_WIDTH-1:0]   bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    fc_accumulate_unit_if.slave    prod,
    fc_accumulate_unit_if.master   out,
    output logic                   busy,
    output logic                   acc_ovf
);

    import fc_pkg::*;

    localparam int SUM_W = ACC_WIDTH + 1;

    fc_state_e              state_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [LEN_WIDTH-1:0]   cnt_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_valid_q;
    logic                   prod_ready_q;
    logic                   busy_q;
    logic                   ovf_q;

    logic [SUM_W-1:0]       sum;
    logic [DATA_WIDTH-1:0]  rq_data;

    assign sum = {1'b0, acc_q} + SUM_W'(prod.data);

    fc_requant #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc   (acc_q),
        .shift (shift_q),
        .q     (rq_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            prod_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= bias;
                        cnt_q   <= vec_len;
                        shift_q <= shift;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (vec_len != '0) begin
                            state_q      <= ACCUM;
                            prod_ready_q <= 1'b1;
                        end else begin
                            state_q <= ROUND;
                        end
                    end
                end
                ACCUM: begin
                    if (prod.valid && prod_ready_q) begin
                        // Clamp at full scale on carry-out and flag it for the rest of the job.
                        if (sum[ACC_WIDTH]) begin
                            acc_q <= {ACC_WIDTH{1'b1}};
                            ovf_q <= 1'b1;
                        end else begin
                            acc_q <= sum[ACC_WIDTH-1:0];
                        end
                        cnt_q <= cnt_q - LEN_WIDTH'(1);
                        if (cnt_q == LEN_WIDTH'(1)) begin
                            state_q      <= ROUND;
                            prod_ready_q <= 1'b0;
                        end
                    end
                end
                ROUND: begin
                    out_data_q  <= rq_data;
                    out_valid_q <= 1'b1;
                    state_q     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_valid_q && out.ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod.ready = prod_ready_q;
    assign out.valid  = out_valid_q;
    assign out.data   = out_data_q;
    assign busy       = busy_q;
    assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_fc_accumulate_unit.sv
// Bench for fc_accumulate_unit: 32-bit and 16-bit accumulator builds driven in lockstep, plus fc_requant standalone.
module tb_fc_accumulate_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] vec_len;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        out_ready;
    logic        busy32, busy16, ovf32, ovf16;

    logic [31:0] rq_acc;
    logic [4:0]  rq_shift;
    logic [7:0]  rq_q;

    int checks = 0;
    int errors = 0;
    int prod_q[$];

    always #5 clk = ~clk;

    fc_accumulate_unit_if #(.WIDTH(16)) p32 ();
    fc_accumulate_unit_if #(.WIDTH(16)) p16 ();
    fc_accumulate_unit_if #(.WIDTH(8))  o32 ();
    fc_accumulate_unit_if #(.WIDTH(8))  o16 ();

    assign p32.valid = prod_valid;
    assign p32.data  = prod_data;
    assign p16.valid = prod_valid;
    assign p16.data  = prod_data;
    assign o32.ready = out_ready;
    assign o16.ready = out_ready;

    fc_accumulate_unit #(.DATA_WIDTH(8), .ACC_WIDTH(32), .LEN_WIDTH(16), .SHIFT_WIDTH(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .bias(bias),
        .shift(shift), .prod(p32), .out(o32), .busy(busy32), .acc_ovf(ovf32));

    fc_accumulate_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(16), .SHIFT_WIDTH(5)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .bias(bias[15:0]),
        .shift(shift), .prod(p16), .out(o16), .busy(busy16), .acc_ovf(ovf16));

    fc_requant #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT_WIDTH(5)) u_rq (
        .acc(rq_acc), .shift(rq_shift), .q(rq_q));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Real-number view of requantization: round half up, then clamp to 0..255.
    function automatic int ref_requant(input longint acc, input int sh);
        longint r;
        r = (sh == 0) ? acc : (acc + (longint'(1) << (sh - 1))) >> sh;
        return (r > 255) ? 255 : int'(r);
    endfunction

    function automatic void model(input longint b, input int accw, input int sh,
                                  output int q, output bit ovf);
        longint maxv, acc;
        maxv = (longint'(1) << accw) - 1;
        acc  = b & maxv;
        ovf  = 1'b0;
        foreach (prod_q[i]) begin
            acc = acc + prod_q[i];
            if (acc > maxv) begin
                acc = maxv;
                ovf = 1'b1;
            end
        end
        q = ref_requant(acc, sh);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy32"}, busy32, 0);
        check({tag, "_busy16"}, busy16, 0);
        check({tag, "_pready32"}, p32.ready, 0);
        check({tag, "_pready16"}, p16.ready, 0);
        check({tag, "_ovalid32"}, o32.valid, 0);
        check({tag, "_ovalid16"}, o16.valid, 0);
        check({tag, "_odata32"}, o32.data, 0);
        check({tag, "_odata16"}, o16.data, 0);
        check({tag, "_ovf32"}, ovf32, 0);
        check({tag, "_ovf16"}, ovf16, 0);
    endtask

    // gap: 0 back-to-back, 1 alternate cycles, 2 random. hold: cycles of out_ready low.
    task automatic do_job(input string tag, input logic [31:0] b, input int len, input int sh,
                          input int gap, input int hold, input bit hs_start);
        int  q32, q16, c, idx, budget;
        bit  ov32, ov16, saw_ready;
        model(longint'(b), 32, sh, q32, ov32);
        model(longint'(b), 16, sh, q16, ov16);
        budget    = 4 * len + 20;
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1; vec_len = 16'(len); bias = b; shift = 5'(sh);
        @(negedge clk);
        start = 1'b0; c = 1; idx = 0; saw_ready = 1'b0;
        check({tag, "_busy_on_start"}, {busy32, busy16}, 2'b11);
        check({tag, "_ovf_cleared"}, {ovf32, ovf16}, 2'b00);
        while (!o32.valid && c < budget) begin
            if (p32.ready) saw_ready = 1'b1;
            if (idx < len && (gap == 0 || (gap == 1 && c % 2 == 1) ||
                              (gap == 2 && $urandom_range(0, 1) == 1))) begin
                prod_valid = 1'b1;
                prod_data  = 16'(prod_q[idx]);
            end else begin
                prod_valid = 1'b0;
            end
            if (prod_valid && p32.ready) idx++;
            @(negedge clk);
            c++;
        end
        prod_valid = 1'b0;
        check({tag, "_out_valid"}, {o32.valid, o16.valid}, 2'b11);
        if (gap == 0) check({tag, "_latency"}, c, len + 2);
        if (len == 0) check({tag, "_no_prod_ready"}, saw_ready, 0);
        check({tag, "_data32"}, o32.data, q32);
        check({tag, "_data16"}, o16.data, q16);
        check({tag, "_ovf32"}, ovf32, ov32);
        check({tag, "_ovf16"}, ovf16, ov16);
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            if (h == 1) begin vec_len = 16'd1; bias = 32'd5; end
            @(negedge clk);
            check({tag, "_hold_valid"}, {o32.valid, o16.valid}, 2'b11);
            check({tag, "_hold_data32"}, o32.data, q32);
            check({tag, "_hold_data16"}, o16.data, q16);
        end
        start     = hs_start;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_valid_dropped"}, {o32.valid, o16.valid}, 2'b00);
        check({tag, "_idle_after"}, {busy32, busy16}, 2'b00);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; vec_len = '0; bias = '0; shift = '0;
        prod_valid = 1'b0; prod_data = '0; out_ready = 1'b1;
        rq_acc = '0; rq_shift = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        prod_q = '{2, 3, 4};
        do_job("basic", 32'd0, 3, 0, 0, 0, 1'b0);
        prod_q = '{1000, 1000};
        do_job("round_sh4", 32'd100, 2, 4, 0, 0, 1'b0);
        do_job("sat_sh2", 32'd100, 2, 2, 0, 0, 1'b0);
        prod_q = '{};
        do_job("zero_len", 32'd37, 0, 0, 0, 0, 1'b0);
        prod_q = '{2, 3, 4};
        do_job("gapped", 32'd0, 3, 0, 1, 0, 1'b0);
        do_job("backpressure", 32'd0, 3, 0, 0, 5, 1'b0);
        prod_q = '{1000};
        do_job("acc_ovf", 32'd65000, 1, 8, 0, 0, 1'b0);
        prod_q = '{7, 9};
        do_job("ovf_clears", 32'd10, 2, 1, 0, 0, 1'b0);
        do_job("start_at_hs", 32'd3, 2, 0, 0, 2, 1'b1);

        // Abandon a job halfway through; nothing from it may leak into the next one.
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1; vec_len = 16'd4; bias = 32'd0; shift = 5'd0;
        @(negedge clk);
        start = 1'b0; prod_valid = 1'b1; prod_data = 16'd10;
        @(negedge clk);
        prod_data = 16'd20;
        @(negedge clk);
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midjob_reset");
        @(negedge clk);
        rst_n = 1'b1;
        prod_q = '{5, 6, 7, 8};
        do_job("after_reset", 32'd1, 4, 0, 0, 0, 1'b0);

        for (int j = 0; j < 15; j++) begin
            int len;
            logic [31:0] b;
            len = $urandom_range(0, 12);
            b   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
            prod_q = '{};
            for (int k = 0; k < len; k++) prod_q.push_back($urandom_range(0, 65535));
            do_job("random", b, len, $urandom_range(0, 12), $urandom_range(0, 2),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        rq_acc = 32'hFFFF_FFFF; rq_shift = 5'd31;
        #1 check("requant_max_sh31", rq_q, ref_requant(longint'(rq_acc), int'(rq_shift)));
        rq_acc = 32'hFFFF_FFFF; rq_shift = 5'd1;
        #1 check("requant_max_sh1", rq_q, ref_requant(longint'(rq_acc), int'(rq_shift)));
        for (int j = 0; j < 10; j++) begin
            rq_acc   = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 4095));
            rq_shift = 5'($urandom_range(0, 31));
            #1 check("requant_random", rq_q, ref_requant(longint'(rq_acc), int'(rq_shift)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_accumulate_unit.md
Name: fc_accumulate_unit

Overview:
- Downstream stage of the FC-layer multiplier. It consumes the stream of unsigned 2*DATA_WIDTH products for one output neuron and accumulates them over a programmable vector length, starting from a bias.
- It then requantizes the sum (rounding right shift plus saturation) back to DATA_WIDTH.
- It presents one output neuron value per job on a valid/ready handshake to the output buffer.

Parameters:
- DATA_WIDTH, 8: operand width of the upstream multiplier; output width.
- ACC_WIDTH, 32: accumulator width; must be >= 2*DATA_WIDTH.
- LEN_WIDTH, 16: width of the vector-length field.
- SHIFT_WIDTH, 5: width of the requantization shift field.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
- vec_len  in  LEN_WIDTH  number of products to accumulate; latched on start.
- bias  in  ACC_WIDTH  unsigned initial accumulator value; latched on start.
- shift  in  SHIFT_WIDTH  requantization right shift; latched on start.
- prod_valid  in  1  product word valid.
- prod_data  in  2*DATA_WIDTH  product from the multiplier.
- prod_ready  out  1  block accepts a product this cycle.
- out_valid  out  1  result valid.
- out_data  out  DATA_WIDTH  requantized, saturated result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in every state except IDLE.
- acc_ovf  out  1  sticky per job; the accumulator saturated during this job.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State becomes IDLE.
  - acc, remaining count, latched shift, out_data, out_valid, prod_ready, busy and acc_ovf all clear to 0.
  - Reset mid-job abandons the job; no partial output is produced.
- FSM states are IDLE, ACCUM, ROUND, OUTPUT.
- IDLE:
  - prod_ready=0.
  - On start: acc<=bias, cnt<=vec_len, shift latched, acc_ovf<=0.
  - Next state is ACCUM if vec_len!=0, else ROUND.
- ACCUM:
  - prod_ready=1 (registered, asserted the cycle after start).
  - Each cycle with prod_valid&&prod_ready: acc<=sat(acc+zero_extend(prod_data)) and cnt<=cnt-1.
  - When the handshake occurs with cnt==1, next state is ROUND and prod_ready drops the following cycle.
  - prod_valid low stalls the block indefinitely with no state change.
- Saturating add:
  - If the ACC_WIDTH+1-bit sum carries out, acc<=all ones and acc_ovf<=1.
  - acc_ovf stays set until the next start.
- ROUND, one cycle:
  - If shift==0: r=acc.
  - Otherwise: r=(acc + (1<<(shift-1)))>>shift, computed in ACC_WIDTH+1 bits so the rounding add cannot wrap.
  - out_data <= (r > 2^DATA_WIDTH-1) ? all ones : r[DATA_WIDTH-1:0].
  - out_valid<=1. Next state is OUTPUT.
- OUTPUT:
  - out_valid and out_data are held stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0 and next state is IDLE.
  - out_ready high on the first OUTPUT cycle completes the handshake that cycle.
- start while busy is ignored.
- start in the same cycle the OUTPUT handshake completes is also ignored; a new job can start in IDLE, one cycle after the output handshake.
- Latency for vec_len=N with no stalls:
  - start at cycle 0, products accepted at cycles 1..N.
  - ROUND at cycle N+1, out_valid visible at cycle N+2.
  - For N=0, out_valid is visible at cycle 2.
- All outputs are registered. There is no combinational path from prod_valid or out_ready to any output.

Decomposition:
- Shared package fc_pkg holds the FSM state encoding (IDLE=0, ACCUM=1, ROUND=2, OUTPUT=3) and the default widths DATA_WIDTH, ACC_WIDTH, LEN_WIDTH and SHIFT_WIDTH.
- One sub-module is natural: fc_requant. It is purely combinational (acc, shift -> saturated DATA_WIDTH value), instantiated in ROUND and unit-tested standalone.

Test Plan:
- Basic job: bias=0, shift=0, vec_len=3, products 2,3,4 back-to-back, out_ready=1 -> out_data=9, out_valid at cycle 5, acc_ovf=0.
- Rounding and saturation:
  - bias=100, shift=4, vec_len=2, products 1000,1000 -> acc=2100, out_data=131.
  - Same job with shift=2 -> r=525, out_data=255 (saturated).
- Zero length: vec_len=0, bias=37, shift=0 -> no prod_ready pulse, out_data=37, out_valid at cycle 2.
- Stalls and backpressure:
  - Same job as the basic test, but prod_valid is gapped (valid on alternate cycles) -> out_data=9.
  - Hold out_ready=0 for 5 cycles -> out_valid and out_data stable throughout; a start pulse during the hold is ignored.
- Accumulator overflow: ACC_WIDTH=16 build, bias=65000, vec_len=1, product 1000, shift=8 -> acc=65535, acc_ovf=1, out_data=255. The next job clears acc_ovf.
- Reset mid-job: rst_n low for 1 cycle after 2 of 4 products -> all outputs 0 immediately, state IDLE. A fresh job then produces the correct, uncontaminated result.
